// File: rtl/rst_seq_mgr.sv
// rst_seq_mgr: fans one system reset out to staggered, stretched per-domain resets
// and records which sources caused them.
module rst_seq_mgr #(
    parameter int unsigned           NumDomains    = 4,
    parameter int unsigned           StretchCycles = 16,
    parameter int unsigned           StagGap       = 4,
    parameter logic [NumDomains-1:0] NdmMask       = 4'b1110
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  prog_rst_ni,
    input  logic                  ndmreset_i,
    input  logic                  sw_rst_req_i,
    input  logic                  cause_clr_i,
    output logic [NumDomains-1:0] rst_no,
    output logic [3:0]            rst_cause_o,
    output logic                  busy_o
);
    localparam int CW = $clog2(StretchCycles + 1);
    localparam int GW = $clog2(StagGap + 1);
    localparam int IW = $clog2(NumDomains + 1);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NumDomains-1:0] rst_q, rst_d;
    logic [3:0]            cause_q, cause_d;
    logic                  busy_q, busy_d;
    logic                  full, part;

    always_comb begin
        full    = ~prog_rst_ni | sw_rst_req_i;
        part    = ndmreset_i & ~full;
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        cause_d = (cause_clr_i ? 4'b0000 : cause_q) | {sw_rst_req_i, ndmreset_i, ~prog_rst_ni, 1'b0};
        if (full | part) begin
            state_d = HOLD;
            cnt_d   = '0;
            gap_d   = '0;
            // a partial source leaves unmasked domains at their current level
            rst_d   = full ? '0 : rst_q & ~NdmMask;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == CW'(StretchCycles - 1)) begin
                        rst_d[0] = 1'b1;
                        idx_d    = IW'(1);
                        gap_d    = '0;
                        state_d  = (NumDomains == 1) ? RUN : RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (gap_q == GW'(StagGap - 1)) begin
                        for (int k = 0; k < NumDomains; k++)
                            if (idx_q == IW'(k)) rst_d[k] = 1'b1;
                        gap_d   = '0;
                        idx_d   = idx_q + IW'(1);
                        state_d = (idx_q == IW'(NumDomains - 1)) ? RUN : RELEASE;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                RUN:     rst_d = '1;
                default: state_d = HOLD;
            endcase
        end
        busy_d = (state_d != RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            gap_q   <= '0;
            idx_q   <= IW'(1);
            rst_q   <= '0;
            cause_q <= 4'b0001;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            cause_q <= cause_d;
            busy_q  <= busy_d;
        end
    end

    assign rst_no      = rst_q;
    assign rst_cause_o = cause_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_rst_seq_mgr.sv
// tb_rst_seq_mgr: scoreboard bench for a default and a minimal rst_seq_mgr,
// checked against a release-time model derived from the quiet-cycle count.
module tb_rst_seq_mgr;
    logic clk = 1'b0;
    logic rst_n = 1'b0, prog_n = 1'b1, ndm = 1'b0, sw = 1'b0, clr = 1'b0;
    int compares = 0, mismatches = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int N = g ? 1 : 4;
        localparam int S = g ? 1 : 16;
        localparam int G = g ? 1 : 4;
        localparam logic [3:0] M = g ? 4'b0001 : 4'b1110;
        localparam logic [N-1:0] MASK = M[N-1:0];

        logic [N-1:0] rst_no;
        logic [3:0]   cause;
        logic         busy;
        logic [N+4:0] sb[$];

        rst_seq_mgr #(.NumDomains(N), .StretchCycles(S), .StagGap(G), .NdmMask(MASK)) dut (
            .clk_i(clk), .rst_ni(rst_n), .prog_rst_ni(prog_n), .ndmreset_i(ndm),
            .sw_rst_req_i(sw), .cause_clr_i(clr), .rst_no(rst_no), .rst_cause_o(cause), .busy_o(busy)
        );

        // q counts consecutive quiet edges; domain k is due once q reaches S + k*G
        int           q = 0;
        logic [N-1:0] held = '1;
        logic         act = 1'b1;
        logic [3:0]   mc = 4'b0001;

        always @(posedge clk) begin
            logic full;
            full = !prog_n || sw;
            if (!rst_n) begin
                held = '1; act = 1'b1; q = 0; mc = 4'b0001;
            end else begin
                mc = (clr ? 4'b0000 : mc) | {sw, ndm, !prog_n, 1'b0};
                if (full || ndm) begin
                    q = 0; act = 1'b1; held = held | (full ? {N{1'b1}} : MASK);
                end else begin
                    q++;
                    for (int k = 0; k < N; k++) if (q >= S + k * G) held[k] = 1'b0;
                    if (q >= S + (N - 1) * G) act = 1'b0;
                end
            end
            sb.push_back({~held, act, mc});
        end

        always @(negedge clk) begin
            logic [N+4:0] e;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compares += 3;
                if (rst_no !== e[N+4:5]) begin
                    mismatches++;
                    $display("FAIL rst_no[%0d] t=%0t got=%b exp=%b", g, $time, rst_no, e[N+4:5]);
                end
                if (busy !== e[4]) begin
                    mismatches++;
                    $display("FAIL busy[%0d] t=%0t got=%b exp=%b", g, $time, busy, e[4]);
                end
                if (cause !== e[3:0]) begin
                    mismatches++;
                    $display("FAIL cause[%0d] t=%0t got=%b exp=%b", g, $time, cause, e[3:0]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(35);
        ndm = 1'b1; cyc(5); ndm = 1'b0;
        cyc(35);
        sw = 1'b1; cyc(1); sw = 1'b0;
        cyc(19);
        sw = 1'b1; cyc(1); sw = 1'b0;
        cyc(35);
        ndm = 1'b1; cyc(2); prog_n = 1'b0; cyc(2); prog_n = 1'b1; cyc(2); ndm = 1'b0;
        cyc(35);
        clr = 1'b1; ndm = 1'b1; cyc(1); clr = 1'b0; ndm = 1'b0;
        cyc(5);
        clr = 1'b1; cyc(1); clr = 1'b0;
        cyc(22);
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        cyc(35);
        repeat (3000) begin
            rst_n  = ($urandom_range(299) != 0);
            prog_n = ($urandom_range(119) != 0);
            ndm    = ($urandom_range(99) < 2);
            sw     = ($urandom_range(119) == 0);
            clr    = ($urandom_range(39) == 0);
            cyc(1);
        end
        rst_n = 1'b1; prog_n = 1'b1; ndm = 1'b0; sw = 1'b0; clr = 1'b0;
        cyc(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end
endmodule
